// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and register scoreboard for the 8x16-bit register file.
// The ALU (req0) and memory (req1) requesters take turns on the single write
// port. The winning request is registered and presented one cycle later. A
// busy bit per register tracks writes that are still outstanding, so the
// issue stage can stall on RAW and WAW hazards.
module regfile_wb_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [2:0]  issue_dest,
  output logic        issue_stall,
  input  logic [2:0]  src_a_addr,
  input  logic [2:0]  src_b_addr,
  output logic        src_a_busy,
  output logic        src_b_busy,
  input  logic        req0_valid,
  input  logic [2:0]  req0_addr,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_addr,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        write_enable,
  output logic [2:0]  write_addr,
  output logic [15:0] write_data,
  output logic [7:0]  busy_vec,
  output logic        wb_err
);

  // Round-robin pointer: 0 = ALU wins a tie, 1 = memory wins a tie.
  logic        prio;

  logic        grant0_p0;
  logic        grant1_p0;
  logic        vld_p0;
  logic [2:0]  addr_p0;
  logic [15:0] data_p0;
  logic        issue_accept;
  logic [7:0]  busy_next;

  // Stage p0: arbitration and hazard queries, from current inputs and registered state only
  always_comb begin
    grant0_p0    = !rst && req0_valid && (!req1_valid || !prio);
    grant1_p0    = !rst && req1_valid && (!req0_valid || prio);
    vld_p0       = grant0_p0 || grant1_p0;
    addr_p0      = grant1_p0 ? req1_addr : req0_addr;
    data_p0      = grant1_p0 ? req1_data : req0_data;
    req0_ready   = grant0_p0;
    req1_ready   = grant1_p0;
    issue_stall  = !rst && issue_valid && busy_vec[issue_dest];
    issue_accept = !rst && issue_valid && !busy_vec[issue_dest];
    src_a_busy   = busy_vec[src_a_addr];
    src_b_busy   = busy_vec[src_b_addr];
  end

  // Scoreboard next state: the presented write clears first, so a same-address issue wins
  always_comb begin
    busy_next = busy_vec;
    if (write_enable) busy_next[write_addr] = 1'b0;
    if (issue_accept) busy_next[issue_dest] = 1'b1;
  end

  // Stage p1: register the granted transfer onto the write port and update the scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= 3'd0;
      write_data   <= 16'd0;
      busy_vec     <= 8'd0;
      wb_err       <= 1'b0;
      prio         <= 1'b0;
    end else begin
      write_enable <= vld_p0;
      busy_vec     <= busy_next;
      if (vld_p0) begin
        write_addr <= addr_p0;
        write_data <= data_p0;
        prio       <= grant0_p0;
        if (!busy_vec[addr_p0]) wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run, all compared against a cycle-level reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic        issue_stall;
  logic [2:0]  src_a_addr, src_b_addr;
  logic        src_a_busy, src_b_busy;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [7:0]  busy_vec;
  logic        wb_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit        m_busy [8];
  bit        m_prio;
  bit        m_we;
  bit [2:0]  m_wa;
  bit [15:0] m_wd;
  bit        m_err;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_stall(issue_stall),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .src_a_busy(src_a_busy), .src_b_busy(src_b_busy),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  function automatic bit [7:0] m_busy_vec();
    bit [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // -1 = nobody granted, 0 = ALU, 1 = memory
  function automatic int m_grant();
    if (rst) return -1;
    if (req0_valid && req1_valid) return m_prio ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_stall();
    return !rst && issue_valid && m_busy[issue_dest];
  endfunction

  // Advance one clock edge and move the model along with it
  task automatic tick();
    int        g     = m_grant();
    bit        st    = m_stall();
    bit        iv    = issue_valid;
    bit [2:0]  id    = issue_dest;
    bit        r     = rst;
    bit [2:0]  ga    = (g == 1) ? req1_addr : req0_addr;
    bit [15:0] gd    = (g == 1) ? req1_data : req0_data;
    bit        nb [8];
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_prio = 0; m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_wa] = 1'b0;
      if (iv && !st) nb[id] = 1'b1;
      if (g >= 0) begin
        if (!m_busy[ga]) m_err = 1'b1;
        m_we = 1; m_wa = ga; m_wd = gd;
        m_prio = (g == 0);
      end else begin
        m_we = 0;
      end
      m_busy = nb;
    end
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_dest = 0; src_a_addr = 0; src_b_addr = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      issue_valid = 1; issue_dest = 3'($urandom);
      src_a_addr = 3'($urandom); src_b_addr = 3'($urandom);
      req0_valid = 1; req0_addr = 3'($urandom); req0_data = 16'($urandom);
      req1_valid = 1; req1_addr = 3'($urandom); req1_data = 16'($urandom);
      #1;
      tests_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || issue_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_comb: ready0=%b ready1=%b stall=%b required 0 0 0", req0_ready, req1_ready, issue_stall);
      end
      tick();
    end
    tests_run++;
    if (write_enable !== 1'b0 || write_addr !== 3'd0 || write_data !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_port: we=%b addr=%0d data=%h required 0 0 0000", write_enable, write_addr, write_data);
    end
    tests_run++;
    if (busy_vec !== 8'h00 || wb_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%h err=%b required 00 0", busy_vec, wb_err);
    end
    rst = 0; idle_inputs(); tick();
  endtask

  task automatic test_single_writeback();
    issue_valid = 1; issue_dest = 3; tick();
    issue_valid = 0;
    tests_run++;
    if (busy_vec !== 8'h08) begin
      tests_failed++; $display("FAIL single_set: busy=%h required 08", busy_vec);
    end
    req0_valid = 1; req0_addr = 3; req0_data = 16'hBEEF; #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL single_grant: ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
    end
    tick(); req0_valid = 0;
    tests_run++;
    if (write_enable !== 1'b1 || write_addr !== 3'd3 || write_data !== 16'hBEEF) begin
      tests_failed++; $display("FAIL single_write: we=%b addr=%0d data=%h required 1 3 beef", write_enable, write_addr, write_data);
    end
    tick(); src_a_addr = 3; #1;
    tests_run++;
    if (busy_vec !== 8'h00 || src_a_busy !== 1'b0 || write_enable !== 1'b0) begin
      tests_failed++; $display("FAIL single_clear: busy=%h src_a_busy=%b we=%b required 00 0 0", busy_vec, src_a_busy, write_enable);
    end
  endtask

  task automatic test_contention();
    bit [2:0]  ea;
    bit [15:0] ed;
    do_reset();
    req0_valid = 1; req0_addr = 1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 2; req1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
        tests_failed++; $display("FAIL contention_grant[%0d]: ready0=%b ready1=%b required %b %b", i, req0_ready, req1_ready, (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      ea = ((i % 2) == 0) ? 3'd1 : 3'd2;
      ed = ((i % 2) == 0) ? 16'h1111 : 16'h2222;
      tests_run++;
      if (write_enable !== 1'b1 || write_addr !== ea || write_data !== ed) begin
        tests_failed++; $display("FAIL contention_write[%0d]: we=%b addr=%0d data=%h required 1 %0d %h", i, write_enable, write_addr, write_data, ea, ed);
      end
    end
    idle_inputs(); tick();
    tests_run++;
    if (write_enable !== 1'b0 || write_addr !== 3'd2 || write_data !== 16'h2222) begin
      tests_failed++; $display("FAIL contention_hold: we=%b addr=%0d data=%h required 0 2 2222", write_enable, write_addr, write_data);
    end
    do_reset();
  endtask

  task automatic test_hazard_stall();
    issue_valid = 1; issue_dest = 5; tick();
    #1;
    src_b_addr = 5; #1;
    tests_run++;
    if (issue_stall !== 1'b1 || src_b_busy !== 1'b1) begin
      tests_failed++; $display("FAIL hazard_stall: stall=%b src_b_busy=%b required 1 1", issue_stall, src_b_busy);
    end
    tick();
    tests_run++;
    if (busy_vec !== 8'h20) begin
      tests_failed++; $display("FAIL hazard_hold: busy=%h required 20", busy_vec);
    end
    req1_valid = 1; req1_addr = 5; req1_data = 16'h5A5A; tick();
    req1_valid = 0; #1;
    tests_run++;
    if (issue_stall !== 1'b1 || write_enable !== 1'b1 || write_addr !== 3'd5) begin
      tests_failed++; $display("FAIL hazard_present: stall=%b we=%b addr=%0d required 1 1 5", issue_stall, write_enable, write_addr);
    end
    tick();
    tests_run++;
    if (issue_stall !== 1'b0 || src_b_busy !== 1'b0 || busy_vec !== 8'h00) begin
      tests_failed++; $display("FAIL hazard_release: stall=%b src_b_busy=%b busy=%h required 0 0 00", issue_stall, src_b_busy, busy_vec);
    end
    tick(); issue_valid = 0;
    tests_run++;
    if (busy_vec !== 8'h20) begin
      tests_failed++; $display("FAIL hazard_reissue: busy=%h required 20", busy_vec);
    end
    req0_valid = 1; req0_addr = 5; tick(); req0_valid = 0; tick();
  endtask

  task automatic test_set_clear();
    issue_valid = 1; issue_dest = 2; tick();
    issue_valid = 0;
    req0_valid = 1; req0_addr = 2; req0_data = 16'h0202; tick();
    req0_valid = 0; issue_valid = 1; issue_dest = 6; tick();
    issue_valid = 0;
    tests_run++;
    if (busy_vec !== 8'h40) begin
      tests_failed++; $display("FAIL set_clear: busy=%h required 40", busy_vec);
    end
    tests_run++;
    if (wb_err !== 1'b0) begin
      tests_failed++; $display("FAIL set_clear_err: err=%b required 0", wb_err);
    end
    req1_valid = 1; req1_addr = 6; tick(); req1_valid = 0; tick();
  endtask

  task automatic test_err_and_reset();
    req1_valid = 1; req1_addr = 7; req1_data = 16'h7777; tick();
    req1_valid = 0;
    tests_run++;
    if (wb_err !== 1'b1 || write_enable !== 1'b1 || write_addr !== 3'd7 || write_data !== 16'h7777) begin
      tests_failed++; $display("FAIL err_write: err=%b we=%b addr=%0d data=%h required 1 1 7 7777", wb_err, write_enable, write_addr, write_data);
    end
    issue_valid = 1; issue_dest = 4; tick(); issue_valid = 0;
    req0_valid = 1; req0_addr = 4; req0_data = 16'h4444; tick();
    rst = 1; #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_ready: ready0=%b required 0", req0_ready);
    end
    tick(); rst = 0; req0_valid = 0;
    tests_run++;
    if (write_enable !== 1'b0 || wb_err !== 1'b0 || busy_vec !== 8'h00) begin
      tests_failed++; $display("FAIL reset_mid: we=%b err=%b busy=%h required 0 0 00", write_enable, wb_err, busy_vec);
    end
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 49) == 0);
      issue_valid = 1'($urandom);
      issue_dest  = 3'($urandom);
      src_a_addr  = 3'($urandom);
      src_b_addr  = 3'($urandom);
      req0_valid  = 1'($urandom);
      req0_addr   = 3'($urandom);
      req0_data   = 16'($urandom);
      req1_valid  = 1'($urandom);
      req1_addr   = 3'($urandom);
      req1_data   = 16'($urandom);
      #1;
      g = m_grant();
      tests_run++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || issue_stall !== m_stall()
          || src_a_busy !== m_busy[src_a_addr] || src_b_busy !== m_busy[src_b_addr]) begin
        tests_failed++;
        $display("FAIL random_comb[%0d]: r0=%b r1=%b st=%b sa=%b sb=%b required %b %b %b %b %b", c,
                 req0_ready, req1_ready, issue_stall, src_a_busy, src_b_busy,
                 g == 0, g == 1, m_stall(), m_busy[src_a_addr], m_busy[src_b_addr]);
      end
      tick();
      tests_run++;
      if (write_enable !== m_we || write_addr !== m_wa || write_data !== m_wd
          || busy_vec !== m_busy_vec() || wb_err !== m_err) begin
        tests_failed++;
        $display("FAIL random_reg[%0d]: we=%b a=%0d d=%h busy=%h err=%b required %b %0d %h %h %b", c,
                 write_enable, write_addr, write_data, busy_vec, wb_err,
                 m_we, m_wa, m_wd, m_busy_vec(), m_err);
      end
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_single_writeback();
    test_contention();
    test_hazard_stall();
    test_set_clear();
    test_err_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and register scoreboard for the 8×16-bit register file. It arbitrates the file's single write port between the ALU and memory write-back requesters using round-robin, and presents one registered write per cycle to the register file write port. It also tracks destination registers with outstanding writes, so the issue stage can stall on RAW and WAW hazards.

## Interface
- No parameters; widths are fixed to the register file (16-bit data, 3-bit address, 8 registers).
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  issue stage wants to dispatch an instruction that writes issue_dest
- issue_dest  in  3  destination register of the issuing instruction
- issue_stall  out  1  combinational: issue_valid && busy[issue_dest]
- src_a_addr, src_b_addr  in  3 each  source registers queried by issue stage
- src_a_busy, src_b_busy  out  1 each  combinational: busy[src_x_addr]
- req0_valid, req0_addr[2:0], req0_data[15:0]  in  ALU write-back request
- req0_ready  out  1  combinational grant to ALU
- req1_valid, req1_addr[2:0], req1_data[15:0]  in  memory write-back request
- req1_ready  out  1  combinational grant to memory
- write_enable  out  1  registered, to the register file write port
- write_addr  out  3  registered
- write_data  out  16  registered
- busy_vec  out  8  registered scoreboard, bit i = register i has a pending write
- wb_err  out  1  sticky: a write-back targeted a register that was not busy

## Operation
- Arbitration:
  - Only one of req0_ready and req1_ready may be high in a cycle.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester indicated by the pointer `prio` wins (0 = ALU, 1 = memory).
  - After any grant, `prio` points to the requester that was not granted.
  - With no valid requester there is no grant and `prio` holds.
  - ready is never high while the corresponding valid is low.
- Transfer: the granted requester's valid && ready. At the next posedge, write_enable=1, write_addr=granted addr, write_data=granted data. With no transfer, write_enable=0 and addr/data hold their previous values.
- Scoreboard:
  - Set: at posedge, busy[issue_dest] ← 1 when issue_valid && !issue_stall.
  - Clear: at posedge, busy[write_addr] ← 0 when write_enable=1, i.e. the edge ending the cycle in which the write is presented.
  - Set and clear of the same address on the same edge: set wins. This is unreachable under correct issue behaviour, but must be implemented.
  - Set and clear of different addresses on the same edge: both take effect.
- wb_err:
  - Set at posedge when a transfer occurs with busy[addr]=0.
  - Cleared only by rst.
  - The write is still performed.
- Both requesters may target the same address in the same cycle. They are serialised by the arbiter; ordering between them is the requesters' responsibility.

## Timing
- Reset: at posedge with rst=1, all of the following are 0:
  - write_enable, write_addr, write_data
  - busy_vec, wb_err
  - prio (ALU preferred)
- During a reset cycle, req0_ready, req1_ready and issue_stall are forced to 0, and issue is ignored.
- Reset mid-operation discards any granted-but-unpresented transfer.
- Write latency: 1 cycle from handshake to write_enable. The register file commits on the following negedge, and a read at the next posedge sees the new data.
- busy bit:
  - Set edge → stays high through the write-presentation cycle.
  - Cleared edge → src_x_busy low in the cycle after write_enable.
  - A read issued in that cycle sees the committed value.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1,…
- All outputs other than ready, issue_stall and src_x_busy are registered. The combinational outputs depend only on current inputs and registered state; there is no combinational loop from ready to valid.

## Test plan
- Reset: drive garbage on all inputs with rst=1 for 2 cycles → write_enable=0, write_addr=0, write_data=0, busy_vec=0x00, wb_err=0, both ready=0.
- Single write-back:
  - Issue dest=3 → busy_vec=0x08.
  - Next, req0 addr=3 data=0xBEEF → req0_ready=1.
  - Next cycle: write_enable=1, addr=3, data=0xBEEF.
  - Following cycle: busy_vec=0x00, src_a_busy(3)=0.
- Contention: both valid for 4 cycles from reset, req0 addr=1 data=0x1111, req1 addr=2 data=0x2222 → grants 0,1,0,1; write stream 1/0x1111, 2/0x2222, 1/0x1111, 2/0x2222.
- Hazard stall:
  - With busy[5]=1, issue dest=5 → issue_stall=1 and busy_vec unchanged.
  - src_b_addr=5 → src_b_busy=1.
  - After write-back to 5 completes → issue_stall=0.
- Simultaneous set/clear: write_enable on addr=2 while issue dest=6 is accepted → next busy_vec has bit 2 clear and bit 6 set.
- Error and reset mid-operation:
  - Write-back to addr=7 with busy[7]=0 → wb_err=1, and the write still appears on the port.
  - Assert rst in the cycle after a grant → write_enable=0 next, wb_err=0, busy_vec=0.
